alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/nrisc_alu_pkg.sv | 48 ++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_alu_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_alu_pkg
// Shared constants for the sequenced ALU controller: opcode values, the ALU
// function-select encoding, FSM state encoding, the default datapath width and
// a request-legality helper.
// Optional feature: ALU_SEQ_NEG_EN (consumed by alu_seq, not by this package).
// -----------------------------------------------------------------------------
package nrisc_alu_pkg;

    localparam int TAM_DEF = 16;

    // Operation codes presented on OP_code
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_NEG = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;

    // ALU function select driven on ULA_op
    localparam logic [2:0] ULA_ADD = 3'd0;
    localparam logic [2:0] ULA_SUB = 3'd1;
    localparam logic [2:0] ULA_AND = 3'd2;
    localparam logic [2:0] ULA_OR  = 3'd3;
    localparam logic [2:0] ULA_XOR = 3'd4;

    // A-side mux input that carries TMP_out
    localparam logic [3:0] SEL_TMP = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // A request is legal when the opcode is implemented and the A index does
    // not point at the temporary register.
    function automatic logic op_legal(input logic [3:0] code,
                                      input logic [3:0] src_a,
                                      input logic       neg_en);
        return (src_a != SEL_TMP) && (code <= OP_OR) &&
               ((code != OP_NEG) || neg_en);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequencing controller for an external combinational ALU fed by two 16:1
// operand muxes. Accepts one operation per handshake, drives mux selects and
// ALU controls for one (or, for NEG, two) execute cycles, captures the ALU
// output and holds it until the consumer takes it.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   OP_valid/OP_ready   request handshake (ready only in IDLE)
//   OP_code             operation code
//   OP_srcA/OP_srcB     operand register indices
//   MUX_selA/MUX_selB   operand mux selects
//   cmp2                forces the A operand to all-ones
//   incdec              forces the B operand to 1
//   ULA_op              ALU function select
//   ULA_result          ALU output (combinational, from outside)
//   TMP_out             temporary register (A-side mux input 15)
//   RES_out/RES_valid/RES_ready  result handshake
//   ERR                 one-cycle pulse after an illegal request
//
// Optional feature: define ALU_SEQ_NEG_EN to enable NEG (two-step ~B+1 via
// TMP_out and state EXEC2). Without it, opcode 4 is illegal and TMP_out is 0.
// -----------------------------------------------------------------------------
module alu_seq
    import nrisc_alu_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           OP_valid,
    output logic           OP_ready,
    input  logic [3:0]     OP_code,
    input  logic [3:0]     OP_srcA,
    input  logic [3:0]     OP_srcB,
    output logic [3:0]     MUX_selA,
    output logic [3:0]     MUX_selB,
    output logic           cmp2,
    output logic           incdec,
    output logic [2:0]     ULA_op,
    input  logic [TAM-1:0] ULA_result,
    output logic [TAM-1:0] TMP_out,
    output logic [TAM-1:0] RES_out,
    output logic           RES_valid,
    input  logic           RES_ready,
    output logic           ERR
);

`ifdef ALU_SEQ_NEG_EN
    localparam logic NEG_EN = 1'b1;
`else
    localparam logic NEG_EN = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [3:0]     code_q, code_d;
    logic [3:0]     srca_q, srca_d;
    logic [3:0]     srcb_q, srcb_d;
    logic [TAM-1:0] res_q, res_d;
    logic [TAM-1:0] tmp_q, tmp_d;
    logic           err_q, err_d;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        res_d    = res_q;
        tmp_d    = tmp_q;
        err_d    = 1'b0;
        MUX_selA = 4'd0;
        MUX_selB = 4'd0;
        cmp2     = 1'b0;
        incdec   = 1'b0;
        ULA_op   = ULA_ADD;

        case (state_q)
            ST_IDLE: begin
                if (OP_valid) begin
                    code_d = OP_code;
                    srca_d = OP_srcA;
                    srcb_d = OP_srcB;
                    // Illegal requests never leave IDLE; ERR shows up next cycle.
                    if (op_legal(OP_code, OP_srcA, NEG_EN)) begin
                        state_d = ST_EXEC1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_EXEC1: begin
                MUX_selA = srca_q;
                MUX_selB = srcb_q;
                case (code_q)
                    OP_ADD: ULA_op = ULA_ADD;
                    OP_SUB: ULA_op = ULA_SUB;
                    OP_INC: begin incdec = 1'b1; ULA_op = ULA_ADD; end
                    OP_DEC: begin incdec = 1'b1; ULA_op = ULA_SUB; end
                    // all-ones XOR B yields ~B; NEG reuses this as its first step
                    OP_NEG, OP_NOT: begin cmp2 = 1'b1; ULA_op = ULA_XOR; end
                    OP_AND: ULA_op = ULA_AND;
                    OP_OR:  ULA_op = ULA_OR;
                    default: ULA_op = ULA_ADD;
                endcase
`ifdef ALU_SEQ_NEG_EN
                if (code_q == OP_NEG) begin
                    tmp_d   = ULA_result;
                    state_d = ST_EXEC2;
                end else begin
                    res_d   = ULA_result;
                    state_d = ST_HOLD;
                end
`else
                res_d   = ULA_result;
                state_d = ST_HOLD;
`endif
            end

            ST_EXEC2: begin
`ifdef ALU_SEQ_NEG_EN
                // TMP_out (~B) + 1 completes the two's-complement negate
                MUX_selA = SEL_TMP;
                MUX_selB = srcb_q;
                incdec   = 1'b1;
                ULA_op   = ULA_ADD;
                res_d    = ULA_result;
                state_d  = ST_HOLD;
`else
                state_d  = ST_IDLE;
`endif
            end

            ST_HOLD: begin
                if (RES_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            code_q  <= 4'd0;
            srca_q  <= 4'd0;
            srcb_q  <= 4'd0;
            res_q   <= '0;
            tmp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            res_q   <= res_d;
            tmp_q   <= tmp_d;
            err_q   <= err_d;
        end
    end

    assign OP_ready  = (state_q == ST_IDLE);
    assign RES_valid = (state_q == ST_HOLD);
    assign RES_out   = res_q;
    assign TMP_out   = tmp_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq. Surrounds the controller with a register file,
// the two operand muxes and a combinational ALU, then runs hand-computed
// vectors. Honours ALU_SEQ_NEG_EN for the NEG-related expectations.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        OP_valid;
    logic        OP_ready;
    logic [3:0]  OP_code;
    logic [3:0]  OP_srcA;
    logic [3:0]  OP_srcB;
    logic [3:0]  MUX_selA;
    logic [3:0]  MUX_selB;
    logic        cmp2;
    logic        incdec;
    logic [2:0]  ULA_op;
    logic [15:0] ULA_result;
    logic [15:0] TMP_out;
    logic [15:0] RES_out;
    logic        RES_valid;
    logic        RES_ready;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] regs [0:15];
    logic [15:0] opa, opb;

    always #5 clk = ~clk;

    alu_seq #(.TAM(16)) dut (
        .clk(clk), .rst(rst),
        .OP_valid(OP_valid), .OP_ready(OP_ready),
        .OP_code(OP_code), .OP_srcA(OP_srcA), .OP_srcB(OP_srcB),
        .MUX_selA(MUX_selA), .MUX_selB(MUX_selB),
        .cmp2(cmp2), .incdec(incdec), .ULA_op(ULA_op),
        .ULA_result(ULA_result), .TMP_out(TMP_out),
        .RES_out(RES_out), .RES_valid(RES_valid), .RES_ready(RES_ready),
        .ERR(ERR)
    );

    // Operand muxes and ALU surrounding the controller
    always_comb begin
        opa = 16'h0000;
        opb = 16'h0000;
        ULA_result = 16'h0000;
        if (cmp2) opa = 16'hFFFF;
        else if (MUX_selA == 4'd15) opa = TMP_out;
        else opa = regs[MUX_selA];
        if (incdec) opb = 16'h0001;
        else if (MUX_selB == 4'd15) opb = TMP_out;
        else opb = regs[MUX_selB];
        case (ULA_op)
            3'd0: ULA_result = opa + opb;
            3'd1: ULA_result = opa - opb;
            3'd2: ULA_result = opa & opb;
            3'd3: ULA_result = opa | opb;
            3'd4: ULA_result = opa ^ opb;
            default: ULA_result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] code, input logic [3:0] a, input logic [3:0] b);
        OP_valid = 1'b1;
        OP_code  = code;
        OP_srcA  = a;
        OP_srcB  = b;
        step();
        OP_valid = 1'b0;
    endtask

    task automatic release_res(input string tag);
        RES_ready = 1'b1;
        step();
        RES_ready = 1'b0;
        chk({tag, "_ready_after"}, {31'd0, OP_ready}, 32'd1);
        chk({tag, "_valid_after"}, {31'd0, RES_valid}, 32'd0);
    endtask

    task automatic run_simple(input string tag, input logic [3:0] code,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] exp_res, input logic exp_id,
                              input logic exp_c2, input logic [2:0] exp_op);
        issue(code, a, b);
        chk({tag, "_selA"},   {28'd0, MUX_selA}, {28'd0, a});
        chk({tag, "_selB"},   {28'd0, MUX_selB}, {28'd0, b});
        chk({tag, "_incdec"}, {31'd0, incdec}, {31'd0, exp_id});
        chk({tag, "_cmp2"},   {31'd0, cmp2}, {31'd0, exp_c2});
        chk({tag, "_ulaop"},  {29'd0, ULA_op}, {29'd0, exp_op});
        step();
        chk({tag, "_valid"},  {31'd0, RES_valid}, 32'd1);
        chk({tag, "_res"},    {16'd0, RES_out}, {16'd0, exp_res});
        release_res(tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        regs[1] = 16'h0003;
        regs[2] = 16'h0004;
        regs[3] = 16'hFFFF;
        regs[4] = 16'h0000;
        regs[5] = 16'h0005;

        rst = 1'b0; OP_valid = 1'b0; OP_code = 4'd0; OP_srcA = 4'd0;
        OP_srcB = 4'd0; RES_ready = 1'b0;
        step(); step();
        chk("rst_res",   {16'd0, RES_out}, 32'd0);
        chk("rst_tmp",   {16'd0, TMP_out}, 32'd0);
        chk("rst_valid", {31'd0, RES_valid}, 32'd0);
        chk("rst_err",   {31'd0, ERR}, 32'd0);
        chk("rst_selA",  {28'd0, MUX_selA}, 32'd0);
        rst = 1'b1;
        step();
        chk("rst_ready", {31'd0, OP_ready}, 32'd1);

        // ADD 3+4 with backpressure
        issue(4'd0, 4'd1, 4'd2);
        chk("add_exec_ready", {31'd0, OP_ready}, 32'd0);
        chk("add_exec_valid", {31'd0, RES_valid}, 32'd0);
        chk("add_exec_selA",  {28'd0, MUX_selA}, 32'd1);
        step();
        chk("add_valid", {31'd0, RES_valid}, 32'd1);
        chk("add_res",   {16'd0, RES_out}, 32'h0007);
        chk("add_hold_ctl", {27'd0, MUX_selA, cmp2}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("add_bp_res",   {16'd0, RES_out}, 32'h0007);
            chk("add_bp_ready", {31'd0, OP_ready}, 32'd0);
            chk("add_bp_valid", {31'd0, RES_valid}, 32'd1);
        end
        release_res("add");

        run_simple("inc", 4'd2, 4'd3, 4'd2, 16'h0000, 1'b1, 1'b0, 3'd0);
        run_simple("dec", 4'd3, 4'd4, 4'd2, 16'hFFFF, 1'b1, 1'b0, 3'd1);
        run_simple("sub", 4'd1, 4'd1, 4'd2, 16'hFFFF, 1'b0, 1'b0, 3'd1);
        run_simple("and", 4'd6, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0, 3'd2);
        run_simple("or",  4'd7, 4'd1, 4'd2, 16'h0007, 1'b0, 1'b0, 3'd3);
        run_simple("not", 4'd5, 4'd1, 4'd2, 16'hFFFB, 1'b0, 1'b1, 3'd4);

        // NEG of 5
        issue(4'd4, 4'd1, 4'd5);
`ifdef ALU_SEQ_NEG_EN
        chk("neg_e1_cmp2",  {31'd0, cmp2}, 32'd1);
        chk("neg_e1_ulaop", {29'd0, ULA_op}, 32'd4);
        step();
        chk("neg_tmp",      {16'd0, TMP_out}, 32'hFFFA);
        chk("neg_e2_selA",  {28'd0, MUX_selA}, 32'd15);
        chk("neg_e2_incdec",{31'd0, incdec}, 32'd1);
        chk("neg_e2_ulaop", {29'd0, ULA_op}, 32'd0);
        chk("neg_e2_valid", {31'd0, RES_valid}, 32'd0);
        step();
        chk("neg_valid", {31'd0, RES_valid}, 32'd1);
        chk("neg_res",   {16'd0, RES_out}, 32'hFFFB);
        release_res("neg");
`else
        chk("neg_err",   {31'd0, ERR}, 32'd1);
        chk("neg_ready", {31'd0, OP_ready}, 32'd1);
        chk("neg_valid", {31'd0, RES_valid}, 32'd0);
        chk("neg_tmp",   {16'd0, TMP_out}, 32'd0);
        step();
        chk("neg_err_end",   {31'd0, ERR}, 32'd0);
        chk("neg_valid_end", {31'd0, RES_valid}, 32'd0);
`endif

        // Illegal opcode 9, then OP_srcA = 15
        issue(4'd9, 4'd1, 4'd2);
        chk("ill9_err",   {31'd0, ERR}, 32'd1);
        chk("ill9_ready", {31'd0, OP_ready}, 32'd1);
        chk("ill9_selA",  {28'd0, MUX_selA}, 32'd0);
        step();
        chk("ill9_err_end", {31'd0, ERR}, 32'd0);
        chk("ill9_valid",   {31'd0, RES_valid}, 32'd0);
        issue(4'd0, 4'd15, 4'd2);
        chk("ilsrc_err",   {31'd0, ERR}, 32'd1);
        chk("ilsrc_ready", {31'd0, OP_ready}, 32'd1);
        step();
        chk("ilsrc_err_end", {31'd0, ERR}, 32'd0);
        chk("ilsrc_valid",   {31'd0, RES_valid}, 32'd0);

        // Reset in the last execute cycle
`ifdef ALU_SEQ_NEG_EN
        issue(4'd4, 4'd1, 4'd5);
        step();
        chk("rstx_pre_selA", {28'd0, MUX_selA}, 32'd15);
`else
        issue(4'd0, 4'd1, 4'd2);
`endif
        rst = 1'b0;
        step();
        chk("rstx_res",    {16'd0, RES_out}, 32'd0);
        chk("rstx_tmp",    {16'd0, TMP_out}, 32'd0);
        chk("rstx_valid",  {31'd0, RES_valid}, 32'd0);
        chk("rstx_ctl",    {25'd0, MUX_selA, cmp2, incdec, ULA_op == 3'd0}, 32'd1);
        chk("rstx_err",    {31'd0, ERR}, 32'd0);
        rst = 1'b1;

        // Reset while holding a result
        issue(4'd0, 4'd1, 4'd2);
        step();
        chk("rsth_pre_res", {16'd0, RES_out}, 32'h0007);
        rst = 1'b0;
        step();
        chk("rsth_res",   {16'd0, RES_out}, 32'd0);
        chk("rsth_valid", {31'd0, RES_valid}, 32'd0);
        rst = 1'b1;
        step();
        chk("rsth_ready", {31'd0, OP_ready}, 32'd1);
        run_simple("fresh", 4'd0, 4'd1, 4'd2, 16'h0007, 1'b0, 1'b0, 3'd0);

        // Immediate release with the next request already waiting
        issue(4'd0, 4'd1, 4'd2);
        step();
        chk("b2b_hold_valid", {31'd0, RES_valid}, 32'd1);
        RES_ready = 1'b1;
        OP_valid = 1'b1; OP_code = 4'd1; OP_srcA = 4'd1; OP_srcB = 4'd2;
        step();
        chk("b2b_idle_ready", {31'd0, OP_ready}, 32'd1);
        chk("b2b_idle_valid", {31'd0, RES_valid}, 32'd0);
        chk("b2b_idle_selA",  {28'd0, MUX_selA}, 32'd0);
        step();
        OP_valid = 1'b0;
        chk("b2b_exec_ready", {31'd0, OP_ready}, 32'd0);
        chk("b2b_exec_ulaop", {29'd0, ULA_op}, 32'd1);
        chk("b2b_exec_selA",  {28'd0, MUX_selA}, 32'd1);
        step();
        chk("b2b_valid", {31'd0, RES_valid}, 32'd1);
        chk("b2b_res",   {16'd0, RES_out}, 32'hFFFF);
        step();
        RES_ready = 1'b0;
        chk("b2b_done_ready", {31'd0, OP_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
